// File: rtl/hilo_ctrl_if.sv
// hilo_ctrl_if: bundle between the EX stage and the HI/LO controller.
//   master : pipeline side. Drives flush, hold, valid, op, rs_data, alu_lo and
//            alu_hi, and observes hi, lo, stall, hilo_we and div_busy.
//   slave  : hilo_ctrl side, with the directions reversed.
interface hilo_ctrl_if;
  logic        flush;
  logic        hold;
  logic        valid;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] alu_lo;
  logic [31:0] alu_hi;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        stall;
  logic        hilo_we;
  logic        div_busy;

  modport master (
    output flush, hold, valid, op, rs_data, alu_lo, alu_hi,
    input  hi, lo, stall, hilo_we, div_busy
  );

  modport slave (
    input  flush, hold, valid, op, rs_data, alu_lo, alu_hi,
    output hi, lo, stall, hilo_we, div_busy
  );
endinterface

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: architectural HI/LO registers and the multi-cycle divide
// sequencer in the EX stage.
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   bus_io   : hilo_ctrl_if.slave
//     inputs  flush, hold, valid, op[2:0], rs_data, alu_lo, alu_hi
//     outputs hi, lo (registered), stall (combinational),
//             hilo_we (registered one-cycle pulse after a write),
//             div_busy (registered, high while waiting on the divider)
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no divide in flight; MULT/MTHI/MTLO write directly
// DIV_WAIT | divide in flight; cnt counts down to the result cycle
// DONE     | result captured into sh_hi/sh_lo, waiting for hold to drop
module hilo_ctrl #(
  parameter int unsigned DIV_CYCLES = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  hilo_ctrl_if.slave  bus_io
);

  localparam int unsigned CNT_W = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_WAIT = 2'd1,
    DONE     = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      sh_hi_q, sh_hi_d;
  logic [31:0]      sh_lo_q, sh_lo_d;
  logic             hilo_we_q, we_d;
  logic             div_busy_q;
  logic             stall_c;
  logic             accept;

  assign accept = bus_io.valid & ~bus_io.flush;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sh_hi_d = sh_hi_q;
    sh_lo_d = sh_lo_q;
    we_d    = 1'b0;
    stall_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (bus_io.op)
            OP_MULT, OP_MULTU: begin
              if (!bus_io.hold) begin
                hi_d = bus_io.alu_hi;
                lo_d = bus_io.alu_lo;
                we_d = 1'b1;
              end
            end
            // A divide starts even under hold: the pipeline freezes on stall.
            OP_DIV, OP_DIVU: begin
              cnt_d   = CNT_LOAD;
              state_d = DIV_WAIT;
              stall_c = 1'b1;
            end
            OP_MTHI: begin
              if (!bus_io.hold) begin
                hi_d = bus_io.rs_data;
                we_d = 1'b1;
              end
            end
            OP_MTLO: begin
              if (!bus_io.hold) begin
                lo_d = bus_io.rs_data;
                we_d = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end

      DIV_WAIT: begin
        if (bus_io.flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q > CNT_ONE) begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - CNT_ONE;
        end else begin
          // Result cycle: EX is released, the divider output is valid now.
          cnt_d = '0;
          if (bus_io.hold) begin
            sh_hi_d = bus_io.alu_hi;
            sh_lo_d = bus_io.alu_lo;
            state_d = DONE;
          end else begin
            hi_d    = bus_io.alu_hi;
            lo_d    = bus_io.alu_lo;
            we_d    = 1'b1;
            state_d = IDLE;
          end
        end
      end

      DONE: begin
        if (bus_io.flush) begin
          state_d = IDLE;
        end else if (!bus_io.hold) begin
          hi_d    = sh_hi_q;
          lo_d    = sh_lo_q;
          we_d    = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      sh_hi_q    <= '0;
      sh_lo_q    <= '0;
      hilo_we_q  <= 1'b0;
      div_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      sh_hi_q    <= sh_hi_d;
      sh_lo_q    <= sh_lo_d;
      hilo_we_q  <= we_d;
      div_busy_q <= (state_d == DIV_WAIT);
    end
  end

  // Gate with rst_n: a divide sitting in EX during reset must not stall.
  assign bus_io.stall    = stall_c & rst_n;
  assign bus_io.hi       = hi_q;
  assign bus_io.lo       = lo_q;
  assign bus_io.hilo_we  = hilo_we_q;
  assign bus_io.div_busy = div_busy_q;

endmodule

// File: tb/tb_hilo_ctrl.sv
module tb_hilo_ctrl;
  localparam int DIVC = 33;

  localparam logic [2:0] NONE  = 3'd0;
  localparam logic [2:0] MULT  = 3'd1;
  localparam logic [2:0] MULTU = 3'd2;
  localparam logic [2:0] DIV   = 3'd3;
  localparam logic [2:0] DIVU  = 3'd4;
  localparam logic [2:0] MTHI  = 3'd5;
  localparam logic [2:0] MTLO  = 3'd6;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   stall_cnt;
  int   busy_cnt;

  hilo_ctrl_if bus();

  hilo_ctrl #(.DIV_CYCLES(DIVC)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a divide is "remaining cycles until the result cycle";
  // a result held off by hold is parked until hold drops.
  logic [31:0] m_hi, m_lo, m_sh_hi, m_sh_lo;
  logic        m_we;
  int          m_left;
  bit          m_parked;

  function automatic bit is_div(input logic [2:0] op);
    return (op == DIV) || (op == DIVU);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi = '0; m_lo = '0; m_sh_hi = '0; m_sh_lo = '0;
      m_we = 1'b0; m_left = 0; m_parked = 1'b0;
    end else begin
      m_we = 1'b0;
      if (m_parked) begin
        if (bus.flush) m_parked = 1'b0;
        else if (!bus.hold) begin
          m_hi = m_sh_hi; m_lo = m_sh_lo; m_we = 1'b1; m_parked = 1'b0;
        end
      end else if (m_left > 0) begin
        if (bus.flush) m_left = 0;
        else if (m_left == 1) begin
          m_left = 0;
          if (bus.hold) begin
            m_sh_hi = bus.alu_hi; m_sh_lo = bus.alu_lo; m_parked = 1'b1;
          end else begin
            m_hi = bus.alu_hi; m_lo = bus.alu_lo; m_we = 1'b1;
          end
        end else m_left = m_left - 1;
      end else if (bus.valid && !bus.flush) begin
        if (is_div(bus.op)) m_left = DIVC - 1;
        else if (!bus.hold) begin
          case (bus.op)
            MULT, MULTU: begin m_hi = bus.alu_hi; m_lo = bus.alu_lo; m_we = 1'b1; end
            MTHI: begin m_hi = bus.rs_data; m_we = 1'b1; end
            MTLO: begin m_lo = bus.rs_data; m_we = 1'b1; end
            default: ;
          endcase
        end
      end
    end
  end

  // Compare process: every falling edge, DUT against the model.
  always @(negedge clk) begin
    logic e_stall;
    if (!rst_n || bus.flush || m_parked) e_stall = 1'b0;
    else if (m_left > 0) e_stall = (m_left > 1);
    else e_stall = bus.valid && is_div(bus.op);
    check("stall", {31'd0, bus.stall}, {31'd0, e_stall});
    check("hi", bus.hi, m_hi);
    check("lo", bus.lo, m_lo);
    check("hilo_we", {31'd0, bus.hilo_we}, {31'd0, m_we});
    check("div_busy", {31'd0, bus.div_busy}, {31'd0, (m_left > 0)});
  end

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] rs,
                       input logic [31:0] ahi, input logic [31:0] alo,
                       input logic hld, input logic fl);
    bus.valid = v; bus.op = op; bus.rs_data = rs;
    bus.alu_hi = ahi; bus.alu_lo = alo; bus.hold = hld; bus.flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, NONE, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(negedge clk);
    stall_cnt += int'(bus.stall);
    busy_cnt  += int'(bus.div_busy);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    errors = 0; checks = 0; stall_cnt = 0; busy_cnt = 0;
    rst_n = 1'b0;
    idle();
    #2;
    drive(1'b1, DIV, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    #1;
    check("rst_stall", {31'd0, bus.stall}, 32'd0);
    check("rst_busy", {31'd0, bus.div_busy}, 32'd0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    check("rst_we", {31'd0, bus.hilo_we}, 32'd0);
    idle();
    @(posedge clk);
    #7 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // MULT all-ones product
    stall_cnt = 0;
    drive(1'b1, MULT, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0);
    tick();
    check("mult_hi", bus.hi, 32'hFFFFFFFF);
    check("mult_lo", bus.lo, 32'hFFFFFFFE);
    check("mult_we", {31'd0, bus.hilo_we}, 32'd1);
    check("mult_stall_cnt", stall_cnt, 32'd0);
    idle(); tick();

    // MULTU held for two cycles
    drive(1'b1, MULTU, 32'd0, 32'hA1A1A1A1, 32'hB2B2B2B2, 1'b1, 1'b0);
    tick(); tick();
    check("hold_mult_hi", bus.hi, 32'hFFFFFFFF);
    bus.hold = 1'b0;
    tick();
    check("hold_release_hi", bus.hi, 32'hA1A1A1A1);
    check("hold_release_lo", bus.lo, 32'hB2B2B2B2);
    idle(); tick();

    // Flush with the request suppresses MULT and DIV
    drive(1'b1, MULT, 32'd0, 32'h11111111, 32'h22222222, 1'b0, 1'b1);
    tick();
    drive(1'b1, DIVU, 32'd0, 32'h3, 32'h4, 1'b0, 1'b1);
    tick();
    check("flush_req_hi", bus.hi, 32'hA1A1A1A1);
    check("flush_req_busy", {31'd0, bus.div_busy}, 32'd0);
    idle(); tick();

    // DIVU, full latency
    stall_cnt = 0; busy_cnt = 0;
    drive(1'b1, DIVU, 32'd0, 32'd2, 32'd7, 1'b0, 1'b0);
    repeat (DIVC) tick();
    check("divu_stall_cycles", stall_cnt, 32'd32);
    check("divu_busy_cycles", busy_cnt, 32'd32);
    check("divu_hi", bus.hi, 32'd2);
    check("divu_lo", bus.lo, 32'd7);
    check("divu_we", {31'd0, bus.hilo_we}, 32'd1);
    idle(); tick();

    // DIV with hold in the result cycle and three more cycles
    drive(1'b1, DIV, 32'd0, 32'h55550005, 32'h66660006, 1'b0, 1'b0);
    repeat (DIVC - 1) tick();
    bus.hold = 1'b1;
    tick();
    bus.alu_hi = 32'hDEADBEEF; bus.alu_lo = 32'hCAFEF00D;
    busy_cnt = 0; stall_cnt = 0;
    repeat (3) tick();
    check("done_hi_unchanged", bus.hi, 32'd2);
    check("done_lo_unchanged", bus.lo, 32'd7);
    check("done_no_restart", busy_cnt, 32'd0);
    bus.hold = 1'b0;
    tick();
    check("done_hi", bus.hi, 32'h55550005);
    check("done_lo", bus.lo, 32'h66660006);
    check("done_stall_cnt", stall_cnt, 32'd0);
    idle(); tick();

    // Flush in cycle 10 of a divide
    stall_cnt = 0;
    drive(1'b1, DIV, 32'd0, 32'h77777777, 32'h88888888, 1'b0, 1'b0);
    repeat (9) tick();
    bus.flush = 1'b1;
    tick();
    check("flush_div_stall_cnt", stall_cnt, 32'd9);
    idle();
    tick();
    check("flush_div_busy", {31'd0, bus.div_busy}, 32'd0);
    check("flush_div_hi", bus.hi, 32'h55550005);
    check("flush_div_we", {31'd0, bus.hilo_we}, 32'd0);

    // MTHI then MTLO back to back
    drive(1'b1, MTHI, 32'h12345678, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    check("mthi_hi", bus.hi, 32'h12345678);
    check("mthi_lo_kept", bus.lo, 32'h66660006);
    check("mthi_we", {31'd0, bus.hilo_we}, 32'd1);
    drive(1'b1, MTLO, 32'h9ABCDEF0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    check("mtlo_lo", bus.lo, 32'h9ABCDEF0);
    check("mtlo_hi_kept", bus.hi, 32'h12345678);
    check("mtlo_we", {31'd0, bus.hilo_we}, 32'd1);
    idle(); tick();

    // MTHI under hold, then an unused opcode
    drive(1'b1, MTHI, 32'h0BADF00D, 32'd0, 32'd0, 1'b1, 1'b0);
    tick();
    check("mthi_hold_hi", bus.hi, 32'h12345678);
    bus.hold = 1'b0;
    tick();
    check("mthi_rel_hi", bus.hi, 32'h0BADF00D);
    drive(1'b1, 3'd7, 32'h13579BDF, 32'h1, 32'h2, 1'b0, 1'b0);
    tick();
    check("op7_hi", bus.hi, 32'h0BADF00D);
    check("op7_we", {31'd0, bus.hilo_we}, 32'd0);
    idle(); tick();

    // Flush in the result cycle, then flush while parked in DONE
    drive(1'b1, DIV, 32'd0, 32'hEEEE0001, 32'hEEEE0002, 1'b0, 1'b0);
    repeat (DIVC - 1) tick();
    bus.flush = 1'b1;
    tick();
    idle(); tick();
    check("flush_final_hi", bus.hi, 32'h0BADF00D);
    check("flush_final_lo", bus.lo, 32'h9ABCDEF0);
    drive(1'b1, DIVU, 32'd0, 32'hEEEE0003, 32'hEEEE0004, 1'b0, 1'b0);
    repeat (DIVC - 1) tick();
    bus.hold = 1'b1;
    tick();
    bus.flush = 1'b1;
    tick();
    idle(); tick();
    check("flush_done_hi", bus.hi, 32'h0BADF00D);
    check("flush_done_we", {31'd0, bus.hilo_we}, 32'd0);

    // Async reset mid-divide (cnt=15), then MULTU straight after release
    drive(1'b1, DIV, 32'd0, 32'h1, 32'h2, 1'b0, 1'b0);
    repeat (18) tick();
    check("pre_rst_busy", {31'd0, bus.div_busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_stall", {31'd0, bus.stall}, 32'd0);
    check("async_rst_hi", bus.hi, 32'd0);
    check("async_rst_lo", bus.lo, 32'd0);
    check("async_rst_busy", {31'd0, bus.div_busy}, 32'd0);
    drive(1'b1, MULTU, 32'd0, 32'hC0DE0001, 32'hC0DE0002, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_multu_hi", bus.hi, 32'hC0DE0001);
    check("post_rst_multu_lo", bus.lo, 32'hC0DE0002);
    idle(); tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
